// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and helpers for the IO bus arbiter slice.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Read value returned with an error completion.
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = 1; v < value; v = v << 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Master-side request/response and peripheral select/ack signals of the IO bus arbiter.
interface io_bus_arbiter_if #(
    parameter int unsigned NR_OF_MASTERS = 2,
    parameter int unsigned NR_OF_SLAVES  = 4,
    parameter int unsigned ADDR_W        = 16
);
    logic [NR_OF_MASTERS-1:0]        m_req;
    logic [NR_OF_MASTERS-1:0]        m_we;
    logic [NR_OF_MASTERS*ADDR_W-1:0] m_addr;
    logic [NR_OF_MASTERS*32-1:0]     m_wdata;
    logic [NR_OF_MASTERS-1:0]        m_done;
    logic                            m_err;
    logic [31:0]                     m_rdata;
    logic [NR_OF_SLAVES-1:0]         s_sel;
    logic                            s_we;
    logic [ADDR_W-1:0]               s_addr;
    logic [31:0]                     s_wdata;
    logic [31:0]                     s_rdata;
    logic [NR_OF_SLAVES-1:0]         s_ack;

    // The arbiter is the slave of the requesters; the environment is the master.
    modport slave (
        input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
        output m_done, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
        input  m_done, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata
    );
endinterface

// File: rtl/io_bus_rr_arbiter.sv
// Combinational round-robin pick: first requester above the last grant, wrapping around.
module io_bus_rr_arbiter
    import io_bus_pkg::*;
#(
    parameter int unsigned NR_OF_MASTERS = 2,
    parameter int unsigned PTR_W = (NR_OF_MASTERS > 1) ? clog2(NR_OF_MASTERS) : 1
) (
    input  logic [NR_OF_MASTERS-1:0] req,
    input  logic [PTR_W-1:0]         last,
    output logic [NR_OF_MASTERS-1:0] grant,
    output logic [PTR_W-1:0]         grant_idx,
    output logic                     any_req
);

    int unsigned cand;
    logic        found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned off = 1; off <= NR_OF_MASTERS; off++) begin
            cand = 32'(last) + off;
            if (cand >= NR_OF_MASTERS) begin
                cand = cand - NR_OF_MASTERS;
            end
            for (int unsigned i = 0; i < NR_OF_MASTERS; i++) begin
                if (!found && (i == cand) && req[i]) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = PTR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// IO bus arbiter: round-robin master grant, region decode, ack wait and registered completion.
// Optional ACCESS timeout with error completion enabled by defining IO_BUS_ARB_TIMEOUT_EN.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int unsigned NR_OF_MASTERS  = 2,
    parameter int unsigned NR_OF_SLAVES   = 4,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic             clk,
    input logic             rst_n,
    io_bus_arbiter_if.slave bus
);

    localparam int unsigned SEL_W = clog2(NR_OF_SLAVES);
    localparam int unsigned PTR_W = (NR_OF_MASTERS > 1) ? clog2(NR_OF_MASTERS) : 1;

    state_t                   state;
    logic [PTR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]         owner;
    logic [NR_OF_MASTERS-1:0] grant;
    logic [PTR_W-1:0]         grant_idx;
    logic                     any_req;
    logic                     pick_we;
    logic [ADDR_W-1:0]        pick_addr;
    logic [31:0]              pick_wdata;
    logic [SEL_W-1:0]         slave_idx;
    logic [NR_OF_SLAVES-1:0]  slave_onehot;
    logic                     ack_hit;

    io_bus_rr_arbiter #(
        .NR_OF_MASTERS(NR_OF_MASTERS),
        .PTR_W        (PTR_W)
    ) u_rr (
        .req      (bus.m_req),
        .last     (rr_ptr),
        .grant    (grant),
        .grant_idx(grant_idx),
        .any_req  (any_req)
    );

    always_comb begin
        pick_we    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int unsigned i = 0; i < NR_OF_MASTERS; i++) begin
            if (grant[i]) begin
                pick_we    = pick_we | bus.m_we[i];
                pick_addr  = pick_addr | bus.m_addr[i*ADDR_W +: ADDR_W];
                pick_wdata = pick_wdata | bus.m_wdata[i*32 +: 32];
            end
        end
    end

    assign slave_idx    = pick_addr[ADDR_W-1 -: SEL_W];
    assign slave_onehot = {{(NR_OF_SLAVES-1){1'b0}}, 1'b1} << slave_idx;
    assign ack_hit      = |(bus.s_ack & bus.s_sel);

`ifdef IO_BUS_ARB_TIMEOUT_EN
    logic [7:0] tcnt;
    logic       err_q;
    assign bus.m_err = err_q;
`else
    assign bus.m_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= PTR_W'(NR_OF_MASTERS - 1);
            owner       <= '0;
            bus.m_done  <= '0;
            bus.m_rdata <= '0;
            bus.s_sel   <= '0;
            bus.s_we    <= 1'b0;
            bus.s_addr  <= '0;
            bus.s_wdata <= '0;
`ifdef IO_BUS_ARB_TIMEOUT_EN
            tcnt        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner       <= grant_idx;
                        rr_ptr      <= grant_idx;
                        bus.s_sel   <= slave_onehot;
                        bus.s_we    <= pick_we;
                        bus.s_addr  <= pick_addr;
                        bus.s_wdata <= pick_wdata;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Completion outputs are registered on the way into DONE so they are valid there.
                    if (ack_hit) begin
                        bus.m_rdata       <= bus.s_rdata;
                        bus.m_done[owner] <= 1'b1;
                        bus.s_sel         <= '0;
                        bus.s_we          <= 1'b0;
                        state             <= DONE;
`ifdef IO_BUS_ARB_TIMEOUT_EN
                        err_q             <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                        if (tcnt + 8'd1 == 8'(TIMEOUT_CYCLES)) begin
                            bus.m_rdata       <= TIMEOUT_RDATA;
                            err_q             <= 1'b1;
                            bus.m_done[owner] <= 1'b1;
                            bus.s_sel         <= '0;
                            bus.s_we          <= 1'b0;
                            state             <= DONE;
                        end
`endif
                    end
                end
                DONE: begin
                    bus.m_done <= '0;
`ifdef IO_BUS_ARB_TIMEOUT_EN
                    tcnt       <= '0;
`endif
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios plus randomized traffic vs a transaction-level model.
module tb_io_bus_arbiter;

    localparam int unsigned NM = 2;
    localparam int unsigned NS = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    io_bus_arbiter_if #(.NR_OF_MASTERS(NM), .NR_OF_SLAVES(NS), .ADDR_W(AW)) bus ();

    io_bus_arbiter #(
        .NR_OF_MASTERS (NM),
        .NR_OF_SLAVES  (NS),
        .ADDR_W        (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Transaction-level view of the requesters and the last granted master.
    bit          pend[NM];
    bit          mwe[NM];
    logic [15:0] maddr[NM];
    logic [31:0] mwd[NM];
    int unsigned last;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_masters();
        for (int i = 0; i < int'(NM); i++) begin
            bus.m_req[i]              = pend[i];
            bus.m_we[i]               = mwe[i];
            bus.m_addr[i*AW +: AW]    = maddr[i];
            bus.m_wdata[i*32 +: 32]   = mwd[i];
        end
    endtask

    task automatic rand_master(input int unsigned i);
        pend[i]  = 1'b1;
        mwe[i]   = 1'($urandom);
        maddr[i] = 16'($urandom);
        mwd[i]   = $urandom;
    endtask

    function automatic int unsigned next_owner();
        for (int unsigned k = 1; k <= NM; k++) begin
            if (pend[(last + k) % NM]) return (last + k) % NM;
        end
        return 0;
    endfunction

    // Starts at an IDLE negedge (fresh) or at the previous DONE negedge; ends at the DONE negedge.
    task automatic run_txn(input bit fresh, input int unsigned delay, input bit noise, input logic [31:0] rd);
        int unsigned own;
        logic [NS-1:0] sel;
        logic [NS-1:0] junk;
        own  = next_owner();
        last = own;
        sel  = NS'(1) << maddr[own][AW-1:AW-2];
        if (!fresh) begin
            @(negedge clk);
            check_eq("idle_gap_sel", bus.s_sel, 0);
            check_eq("done_one_cycle", bus.m_done, 0);
        end
        @(negedge clk);
        check_eq("sel", bus.s_sel, sel);
        check_eq("s_we", bus.s_we, mwe[own]);
        check_eq("s_addr", bus.s_addr, maddr[own]);
        check_eq("s_wdata", bus.s_wdata, mwd[own]);
        for (int unsigned c = 0; c <= delay; c++) begin
            junk = (NS'($urandom) | NS'(1)) & ~sel;
            bus.s_rdata = (c == delay) ? rd : $urandom;
            if (c == delay) bus.s_ack = sel | (noise ? junk : '0);
            else            bus.s_ack = noise ? junk : '0;
            @(negedge clk);
            if (c < delay) begin
                check_eq("wait_no_done", bus.m_done, 0);
                check_eq("sel_hold", bus.s_sel, sel);
                check_eq("addr_hold", bus.s_addr, maddr[own]);
            end
        end
        bus.s_ack = '0;
        check_eq("done", bus.m_done, NM'(1) << own);
        check_eq("rdata", bus.m_rdata, rd);
        check_eq("err", bus.m_err, 0);
        check_eq("done_sel_clear", bus.s_sel, 0);
        check_eq("done_we_clear", bus.s_we, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.m_req   = '0;
        bus.m_we    = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.s_ack   = '0;
        bus.s_rdata = '0;
        for (int i = 0; i < int'(NM); i++) begin
            pend[i] = 1'b0; mwe[i] = 1'b0; maddr[i] = '0; mwd[i] = '0;
        end
        last = NM - 1;

        repeat (2) @(negedge clk);
        check_eq("rst_outputs", {bus.m_done, bus.m_err, bus.m_rdata, bus.s_sel, bus.s_we, bus.s_addr}, 0);
        check_eq("rst_wdata", bus.s_wdata, 0);
        rst_n = 1'b1;

        // Single read, ack on the second ACCESS cycle.
        pend[0] = 1'b1; mwe[0] = 1'b0; maddr[0] = 16'h4010; mwd[0] = $urandom;
        drive_masters();
        run_txn(1'b1, 1, 1'b0, 32'hDEADBEEF);

        // Write with immediate ack.
        pend[0] = 1'b0;
        pend[1] = 1'b1; mwe[1] = 1'b1; maddr[1] = 16'hC000; mwd[1] = 32'h12345678;
        drive_masters();
        run_txn(1'b0, 0, 1'b0, $urandom);

        // Contention: both masters hold requests.
        rand_master(0);
        rand_master(1);
        drive_masters();
        for (int n = 0; n < 4; n++) begin
            run_txn(1'b0, $urandom_range(0, 2), 1'b0, $urandom);
            rand_master(last);
            drive_masters();
        end

        // Ack from an unselected slave must be ignored.
        pend[1] = 1'b0;
        pend[0] = 1'b1; mwe[0] = 1'b0; maddr[0] = 16'h8000;
        drive_masters();
        run_txn(1'b0, 3, 1'b1, $urandom);

        // No ack at all: timeout completion or indefinite wait.
        last = 0;
        @(negedge clk);
        @(negedge clk);
        check_eq("to_sel", bus.s_sel, 4'b0100);
`ifdef IO_BUS_ARB_TIMEOUT_EN
        for (int k = 1; k < int'(TO); k++) begin
            @(negedge clk);
            check_eq("to_wait", bus.m_done, 0);
        end
        @(negedge clk);
        check_eq("to_done", bus.m_done, 2'b01);
        check_eq("to_err", bus.m_err, 1);
        check_eq("to_rdata", bus.m_rdata, 0);
        rand_master(0);
        rand_master(1);
        drive_masters();
        last = next_owner();
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_sel", bus.s_sel != 0, 1);
`else
        begin
            int unsigned seen;
            seen = 0;
            repeat (100) begin
                @(negedge clk);
                if (bus.m_done != 0) seen++;
            end
            check_eq("no_timeout_done", seen, 0);
            check_eq("still_waiting_sel", bus.s_sel, 4'b0100);
        end
`endif

        // Reset mid-ACCESS: outputs clear asynchronously, no completion.
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_rst_outputs", {bus.m_done, bus.m_err, bus.m_rdata, bus.s_sel, bus.s_we, bus.s_addr}, 0);
        check_eq("async_rst_wdata", bus.s_wdata, 0);
        @(negedge clk);
        check_eq("rst_no_done", bus.m_done, 0);
        rst_n = 1'b1;
        last = NM - 1;
        rand_master(0);
        rand_master(1);
        drive_masters();
        run_txn(1'b1, 0, 1'b0, $urandom);
        check_eq("first_after_rst", last, 0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) pend[last] = 1'b0;
            else                           rand_master(last);
            for (int unsigned j = 0; j < NM; j++) begin
                if (!pend[j] && ($urandom_range(0, 1) == 1)) rand_master(j);
            end
            if (!pend[0] && !pend[1]) rand_master($urandom_range(0, NM - 1));
            drive_masters();
            run_txn(1'b0, $urandom_range(0, 4), 1'($urandom), $urandom);
        end

        @(negedge clk);
        check_eq("final_done_one_cycle", bus.m_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
Shares the core IO bus between NR_OF_MASTERS requesters (core data port, DMA, debug) and sequences each access to NR_OF_SLAVES peripherals. Per-slave selection uses round-robin master arbitration and address-region decode. Waits for the selected slave's ack and registers the read data from the OR-merged IO read bus (the io_bus_dmux output). Sits between the masters and the peripheral select/read-data fabric.

Parameters:
NR_OF_MASTERS, 2, number of requesters; must be ≥1.
NR_OF_SLAVES, 4, number of peripherals; must be a power of two, ≥2.
ADDR_W, 16, IO address width.
TIMEOUT_CYCLES, 15, maximum ACCESS cycles before an error completion; range 1..255.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
m_req  in  NR_OF_MASTERS  per-master request level.
m_we  in  NR_OF_MASTERS  per-master write enable; 1 = write.
m_addr  in  NR_OF_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W].
m_wdata  in  NR_OF_MASTERS*32  packed write data.
m_done  out  NR_OF_MASTERS  one-cycle completion pulse to the owning master.
m_err  out  1  valid with m_done; 1 = timeout.
m_rdata  out  32  registered read data; valid with m_done.
s_sel  out  NR_OF_SLAVES  one-hot slave select.
s_we  out  1  write strobe qualifier.
s_addr  out  ADDR_W  latched address.
s_wdata  out  32  latched write data.
s_rdata  in  32  merged slave read data (OR of all slave buses).
s_ack  in  NR_OF_SLAVES  per-slave acknowledge.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE; rr pointer = NR_OF_MASTERS-1, so master 0 has first priority.
  - m_done=0, m_err=0, m_rdata=0, s_sel=0, s_we=0, s_addr=0, s_wdata=0, timeout counter=0.
  - Reset asserted mid-transaction aborts it; no m_done is issued.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any m_req is high, grant the first requester searching upward from rr pointer+1, with wrap-around.
  - Latch the owner index, m_we, m_addr and m_wdata of the granted master.
  - Decode slave index = addr[ADDR_W-1 -: log2(NR_OF_SLAVES)].
  - Register s_sel one-hot, s_we, s_addr and s_wdata; go to ACCESS.
  - rr pointer = granted index.
- ACCESS:
  - s_sel, s_we, s_addr and s_wdata are held stable.
  - If s_ack of the selected slave = 1: m_rdata <= s_rdata (writes also capture), m_err <= 0, go to DONE.
  - s_ack from unselected slaves is ignored.
  - Timeout counter increments each ACCESS cycle without ack.
- DONE:
  - s_sel=0, s_we=0.
  - m_done[owner]=1 for exactly this cycle; clear timeout counter; go to IDLE.
- Latency: m_req rise (seen in IDLE) at cycle 0 -> s_sel at cycle 1 -> ack sampled at cycle 1 at earliest -> m_done at cycle 2. Minimum 3 cycles per access; no back-to-back without IDLE.
- Master protocol:
  - Hold m_req and its request fields until m_done; then drop m_req or present the next request.
  - A req dropped during ACCESS does not abort; the transaction completes.
- Simultaneous requests: round-robin guarantees each requester is granted within NR_OF_MASTERS transactions.
- m_rdata and m_err hold their last value until the next completion.

Optional Feature:
IO_BUS_ARB_TIMEOUT_EN:
- Defined: if the counter reaches TIMEOUT_CYCLES in ACCESS without ack, go to DONE with m_err=1 and m_rdata=32'h0.
- Undefined: the counter is not built; ACCESS waits indefinitely; m_err is tied 0.

Decomposition:
- Package io_bus_pkg holds:
  - state encodings IDLE=2'd0, ACCESS=2'd1, DONE=2'd2;
  - the clog2 helper function;
  - the timeout error read value 32'h0.
- Sub-module io_bus_rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, last-grant pointer.
  - Outputs: one-hot grant, grant index, any_req.

Test Plan:
- Single read: master0 req, addr=16'h4010, slave1 ack with s_rdata=32'hDEADBEEF on its 2nd ACCESS cycle -> s_sel=4'b0010 from cycle 1; m_done[0] pulse at cycle 3; m_rdata=32'hDEADBEEF; m_err=0.
- Contention: m_req=2'b11 held after reset -> grants in order 0,1,0,1; each m_done one cycle; s_sel never overlaps; IDLE cycle between accesses.
- Write: master1 we=1, addr=16'hC000, wdata=32'h12345678, immediate slave3 ack -> s_sel=4'b1000, s_we=1, s_wdata held; m_done[1] at cycle 2.
- Timeout (macro defined): addr=16'h8000, no ack -> m_done with m_err=1, m_rdata=0 after 15 ACCESS cycles. Macro undefined: no completion after 100 cycles.
- Wrong-slave ack: selected slave2, s_ack=4'b0001 pulsed -> ignored; completes only on s_ack[2].
- Reset mid-ACCESS: rst_n low for 1 cycle during ACCESS -> outputs zero immediately (asynchronous), no m_done; master0 granted first after release.
